// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin sharing of one float16 multiplier between
// N_REQ requesters, with an in-order tag FIFO that routes results back.
// Optional per-requester grant statistics: define MUL_RR_SCHED_STATS_EN.
module mul_rr_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N_REQ-1:0]     REQ_VALID,
  output logic [N_REQ-1:0]     REQ_READY,
  input  logic [N_REQ*16-1:0]  REQ_A,
  input  logic [N_REQ*16-1:0]  REQ_B,
  output logic                 MUL_DVI,
  output logic [31:0]          MUL_DI,
  input  logic                 MUL_DVO,
  input  logic [5:0]           MUL_P_TYPE,
  input  logic [15:0]          MUL_P,
  output logic [N_REQ-1:0]     RES_VALID,
  output logic [5:0]           RES_TYPE,
  output logic [15:0]          RES_P,
  output logic                 BUSY,
`ifdef MUL_RR_SCHED_STATS_EN
  input  logic                 STATS_CLR,
  output logic [N_REQ*16-1:0]  GRANT_CNT,
`endif
  output logic [1:0]           ERR
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW  = IDW + 1;
  localparam int unsigned AW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned OW  = $clog2(TAG_DEPTH + 1);
  localparam int unsigned CW  = 3;

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [SW-1:0]  sum;
  logic           grant;
  logic [N_REQ-1:0] elig;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;

  logic [CW-1:0]  cnt_q [N_REQ];
  logic [IDW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [OW-1:0]  occ_q;
  logic [OW-1:0]  occ_nxt;
  logic           full;
  logic           empty;
  logic           push_ok;
  logic           pop_ok;
  logic [IDW-1:0] tag;
  logic [N_REQ-1:0] grant_hot;
  logic [N_REQ-1:0] tag_hot;

  assign full    = (occ_q == OW'(TAG_DEPTH));
  assign empty   = (occ_q == '0);
  assign push_ok = grant && !full;
  assign pop_ok  = MUL_DVO && !empty;
  assign tag     = tag_mem[rd_q];

  // Eligibility, round-robin winner search from ptr, and operand select
  always_comb begin
    elig      = '0;
    grant     = 1'b0;
    win       = '0;
    idx       = '0;
    sum       = '0;
    sel_a     = '0;
    sel_b     = '0;
    grant_hot = '0;
    tag_hot   = '0;
    REQ_READY = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = REQ_VALID[i] && (cnt_q[i] < CW'(MAX_OUTST)) && !full;
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      idx = sum[IDW-1:0];
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = REQ_A[i*16 +: 16];
        sel_b = REQ_B[i*16 +: 16];
      end
      grant_hot[i] = push_ok && (win == IDW'(i));
      tag_hot[i]   = pop_ok && (tag == IDW'(i));
    end
    if (grant) REQ_READY[win] = 1'b1;
  end

  // Next tag FIFO occupancy
  always_comb begin
    occ_nxt = occ_q;
    case ({push_ok, pop_ok})
      2'b10:   occ_nxt = occ_q + 1'b1;
      2'b01:   occ_nxt = occ_q - 1'b1;
      default: occ_nxt = occ_q;
    endcase
  end

  // Issue stage: registered multiplier request and round-robin pointer
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q   <= '0;
      MUL_DVI <= 1'b0;
      MUL_DI  <= '0;
    end else begin
      MUL_DVI <= grant;
      if (grant) begin
        MUL_DI <= {sel_b, sel_a};
        ptr_q  <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  // Tag storage; contents need no reset since occupancy guards every read
  always_ff @(posedge CLK) begin
    if (push_ok) tag_mem[wr_q] <= win;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_ok) wr_q <= (wr_q == AW'(TAG_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop_ok)  rd_q <= (rd_q == AW'(TAG_DEPTH - 1)) ? '0 : rd_q + 1'b1;
      occ_q <= occ_nxt;
    end
  end

  // Per-requester outstanding counters; simultaneous grant and result cancel
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_hot[i] && !tag_hot[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (tag_hot[i] && !grant_hot[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Result routing, busy flag and sticky protocol errors
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RES_VALID <= '0;
      RES_TYPE  <= '0;
      RES_P     <= '0;
      BUSY      <= 1'b0;
      ERR       <= '0;
    end else begin
      RES_VALID <= tag_hot;
      if (pop_ok) begin
        RES_TYPE <= MUL_P_TYPE;
        RES_P    <= MUL_P;
      end
      BUSY <= (occ_nxt != '0) || grant;
      if (grant && full)    ERR[0] <= 1'b1;
      if (MUL_DVO && empty) ERR[1] <= 1'b1;
    end
  end

`ifdef MUL_RR_SCHED_STATS_EN
  // Saturating grant counters; clear takes priority over increment
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      GRANT_CNT <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (STATS_CLR) GRANT_CNT[i*16 +: 16] <= '0;
        else if (grant_hot[i] && (GRANT_CNT[i*16 +: 16] != 16'hFFFF))
          GRANT_CNT[i*16 +: 16] <= GRANT_CNT[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
